// File: rtl/byte_mem_arbiter.sv
// Round-robin arbiter sharing one byte-wide synchronous RAM between fetch (read-only)
// and data (read/write) ports; each 32-bit access is serialised into four big-endian beats.
//
// state | meaning
// IDLE  | waiting for a request, arbitrate on the next edge
// BEAT  | four memory beats, cnt 0..3
// DRAIN | reads only: capture the last returned byte
// RESP  | one-cycle ack to the owning port
module byte_mem_arbiter #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_ack,
  output logic [31:0]           if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [31:0]           d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_ack,
  output logic [31:0]           d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, BEAT, DRAIN, RESP} state_t;

  state_t                state, state_nxt;
  logic [1:0]            cnt;
  logic                  last_d;
  logic                  own_d;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] base;
  logic [31:0]           wdata_q;
  logic [31:0]           rbuf;
  logic                  grant_d;
  logic                  addr_hi_unused;

  assign addr_hi_unused = ^{if_addr[31:ADDR_WIDTH], d_addr[31:ADDR_WIDTH]};

  // data wins when alone, or on a tie when fetch was granted last
  assign grant_d = d_req && (!if_req || !last_d);

  function automatic logic [31:0] put_lane(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (lane)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      last_d   <= 1'b0;
      own_d    <= 1'b0;
      we_q     <= 1'b0;
      base     <= '0;
      wdata_q  <= 32'd0;
      rbuf     <= 32'd0;
      if_rdata <= 32'd0;
      d_rdata  <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            own_d   <= grant_d;
            last_d  <= grant_d;
            we_q    <= grant_d && d_we;
            base    <= grant_d ? d_addr[ADDR_WIDTH-1:0] : if_addr[ADDR_WIDTH-1:0];
            wdata_q <= d_wdata;
            cnt     <= 2'd0;
          end
        end
        BEAT: begin
          cnt <= cnt + 2'd1;
          // read data trails its beat by one cycle
          if (!we_q && cnt != 2'd0)
            rbuf <= put_lane(rbuf, cnt - 2'd1, mem_rdata);
        end
        DRAIN: begin
          if (own_d) d_rdata  <= {rbuf[31:8], mem_rdata};
          else       if_rdata <= {rbuf[31:8], mem_rdata};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'd0;
    case (state)
      IDLE:  if (if_req || d_req) state_nxt = BEAT;
      BEAT: begin
        mem_en   = 1'b1;
        mem_we   = we_q;
        mem_addr = base + ADDR_WIDTH'(cnt);
        if (we_q) begin
          case (cnt)
            2'd0:    mem_wdata = wdata_q[31:24];
            2'd1:    mem_wdata = wdata_q[23:16];
            2'd2:    mem_wdata = wdata_q[15:8];
            default: mem_wdata = wdata_q[7:0];
          endcase
        end
        if (cnt == 2'd3) state_nxt = we_q ? RESP : DRAIN;
      end
      DRAIN: state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign if_ack = (state == RESP) && !own_d;
  assign d_ack  = (state == RESP) && own_d;
  assign busy   = (state != IDLE);

endmodule

// File: doc/byte_mem_arbiter.md
Name: byte_mem_arbiter

Overview:
- Shares one byte-wide, single-ported synchronous memory between two requesters: the instruction-fetch stage (read only) and the data-memory stage (read/write).
- Each granted 32-bit word access is serialised into four byte beats.
- Bytes are assembled big-endian: byte at base+0 goes to [31:24], base+3 goes to [7:0].
- Arbitration is round-robin, one transaction at a time. The block sits between the pipeline's fetch/memory stages and the shared byte RAM.

Parameters:
- ADDR_WIDTH, 11, byte-address width of the shared memory (2048 bytes).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- if_req  input  1  fetch request; held high until if_ack.
- if_addr  input  32  fetch byte address; held stable while if_req is high.
- if_ack  output  1  one-cycle pulse; if_rdata is valid in this cycle.
- if_rdata  output  32  assembled fetch word; holds its value until the next if_ack.
- d_req  input  1  data request; held high until d_ack.
- d_we  input  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  input  32  data byte address; stable while d_req is high.
- d_wdata  input  32  write word; stable while d_req is high.
- d_ack  output  1  one-cycle completion pulse.
- d_rdata  output  32  assembled read word; holds its value until the next read d_ack.
- mem_en  output  1  memory beat enable.
- mem_we  output  1  memory write enable (only when mem_en is high).
- mem_addr  output  ADDR_WIDTH  beat byte address.
- mem_wdata  output  8  write byte.
- mem_rdata  input  8  read byte, valid the cycle after the mem_en read beat.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IDLE; beat counter = 0; last-grant = IF.
  - All outputs are 0: acks, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy.
  - Reset mid-transaction aborts it immediately. No ack is issued and no further beats occur.
- States: IDLE, BEAT, DRAIN, RESP.
- IDLE:
  - Samples if_req/d_req. If either is high, the edge latches the winner, base address, direction and write word, clears the counter, and moves to BEAT.
  - Base address = addr[ADDR_WIDTH-1:0]; upper bits are ignored. No alignment is forced.
  - Arbitration:
    - Only one requester high: it wins.
    - Both high: the port not granted last wins. After reset, data wins the first tie.
    - last-grant updates on each grant.
- BEAT (4 cycles, cnt 0..3):
  - mem_en=1; mem_addr = base+cnt, modulo 2^ADDR_WIDTH (wraps to 0).
  - Write beats: mem_we=1 and mem_wdata = byte cnt of the write word ([31:24] first).
  - Read beats: mem_we=0, and the byte returned in the following cycle is captured into lane cnt.
  - After cnt=3: read goes to DRAIN; write goes to RESP.
- DRAIN (reads only): mem_en=0; the final byte (lane 3) is captured.
- RESP:
  - The owning port's ack is high for exactly one cycle.
  - For reads, the owning rdata register updates on entry to RESP, so it is valid while ack is high. The other port's rdata is unchanged.
  - Next state is IDLE.
- Latency (request high in cycle 0, state IDLE):
  - Read: beats in cycles 1–4, DRAIN in cycle 5, ack in cycle 6.
  - Write: beats in cycles 1–4, ack in cycle 5.
- Back-to-back: the minimum gap between transactions is one IDLE cycle.
- Requester protocol: req is deasserted in the cycle after ack, and is sampled only in IDLE. A req still high in IDLE is treated as a new request.
- A req dropped or an input changed mid-transaction is a protocol violation. The latched values are used, the transaction completes, and ack still pulses.
- mem_en is never high in IDLE, DRAIN or RESP. mem_we is never high on an IF transaction.
- d_rdata is not updated by data writes.

Test Plan:
- Single fetch: preload bytes 0x0C..0x0F = E3,A0,10,05; if_req with if_addr=0x0C -> mem_addr 0x00C..0x00F in cycles 1–4, if_ack in cycle 6, if_rdata=0xE3A01005, d_ack stays 0.
- Data write then read: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> mem_we beats DE,AD,BE,EF at 0x100..0x103, d_ack in cycle 5. Then a read of 0x100 -> d_rdata=0xDEADBEEF in cycle 6; if_rdata unchanged.
- Contention: if_req and d_req both high after reset -> data served first, IF next (if_ack 7 cycles after d_ack for a data read). A repeated simultaneous request then grants IF (round-robin alternation).
- Wrap: fetch at if_addr=0x7FE -> mem_addr sequence 0x7FE, 0x7FF, 0x000, 0x001; upper address bits 0xFFFF_F800 are ignored.
- Reset mid-op: assert rst=0 during beat 2 of a read -> mem_en, busy and ack are 0 immediately, no ack is issued after release, and a fresh request completes normally.
- Protocol: d_req dropped in cycle 2 of a write -> all 4 beats still issue and d_ack still pulses in cycle 5.
